// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard control for the EX-stage operand muxes.
// Tracks destination tags for EX and MEM and registers the mux selects on each ID->EX advance.
package forward_ctrl_pkg;
  typedef enum logic [1:0] {
    ZERO    = 2'd0,
    DEFAULT = 2'd1,
    TOP     = 2'd2,
    BOTTOM  = 2'd3
  } cmd_t;
endpackage

module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  output logic             stall,
  output logic             ex_valid,
  output cmd_t             ex_cmd1,
  output cmd_t             ex_cmd2
);

  if (NREGS > (1 << REG_W)) begin : g_bad_params
    $error("forward_ctrl: NREGS does not fit in REG_W bits");
  end

  logic             ex_valid_q, ex_we_q, ex_load_q;
  logic [REG_W-1:0] ex_rd_q;
  logic             mem_valid_q, mem_we_q;
  logic [REG_W-1:0] mem_rd_q;
  cmd_t             ex_cmd1_q, ex_cmd2_q;

  cmd_t             sel1_d, sel2_d;
  logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic             ex_load_live;

  assign ex_hit1  = ex_valid_q  && ex_we_q  && (ex_rd_q  == id_rs1);
  assign ex_hit2  = ex_valid_q  && ex_we_q  && (ex_rd_q  == id_rs2);
  assign mem_hit1 = mem_valid_q && mem_we_q && (mem_rd_q == id_rs1);
  assign mem_hit2 = mem_valid_q && mem_we_q && (mem_rd_q == id_rs2);

  // rs==0 resolves to ZERO before any tag compare, so rd=0 entries never forward.
  always_comb begin
    sel1_d = DEFAULT;
    if (id_rs1_used) begin
      if (id_rs1 == '0)  sel1_d = ZERO;
      else if (ex_hit1)  sel1_d = TOP;
      else if (mem_hit1) sel1_d = BOTTOM;
    end
  end

  always_comb begin
    sel2_d = DEFAULT;
    if (id_rs2_used) begin
      if (id_rs2 == '0)  sel2_d = ZERO;
      else if (ex_hit2)  sel2_d = TOP;
      else if (mem_hit2) sel2_d = BOTTOM;
    end
  end

  assign ex_load_live = ex_valid_q && ex_load_q && ex_we_q && (ex_rd_q != '0);
  assign stall = id_valid && ex_load_live &&
                 ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                  (id_rs2_used && (id_rs2 == ex_rd_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= '0;
      ex_cmd1_q   <= DEFAULT;
      ex_cmd2_q   <= DEFAULT;
    end else if (flush) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      ex_cmd1_q   <= DEFAULT;
      ex_cmd2_q   <= DEFAULT;
    end else if (!hold) begin
      mem_valid_q <= ex_valid_q;
      mem_we_q    <= ex_we_q;
      mem_rd_q    <= ex_rd_q;
      if (id_valid && !stall) begin
        ex_valid_q <= 1'b1;
        ex_we_q    <= id_rd_we;
        ex_load_q  <= id_is_load;
        ex_rd_q    <= id_rd;
        ex_cmd1_q  <= sel1_d;
        ex_cmd2_q  <= sel2_d;
      end else begin
        ex_valid_q <= 1'b0;
        ex_we_q    <= 1'b0;
        ex_load_q  <= 1'b0;
        ex_cmd1_q  <= DEFAULT;
        ex_cmd2_q  <= DEFAULT;
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_cmd1  = ex_cmd1_q;
  assign ex_cmd2  = ex_cmd2_q;

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Forwarding and hazard controller that drives the `cmd_t` select inputs of the two operand muxes (`OpMux3`) at the EX stage.
- Keeps a shadow pipeline of destination-register tags for EX and MEM.
- On each ID→EX advance it computes and registers the select for operand 1 and operand 2.
- Detects load-use hazards and requests a one-cycle ID stall, inserting a bubble into EX.

Parameters:
- REG_W, 5, width of a register index.
- NREGS, 32, number of architectural registers; index 0 is hard-wired zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  global pipeline freeze (e.g. memory wait); all state holds
- flush  in  1  branch/exception flush; kills EX and MEM entries
- id_valid  in  1  instruction present in ID
- id_rs1 / id_rs2  in  REG_W  source register indices
- id_rs1_used / id_rs2_used  in  1  source actually read by the instruction
- id_rd  in  REG_W  destination index
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- stall  out  1  combinational; ID must not advance this cycle
- ex_valid  out  1  registered; EX holds a real instruction
- ex_cmd1 / ex_cmd2  out  cmd_t  registered mux selects for operand 1 and operand 2

Behaviour:
- Mux select meaning:
  - ZERO = constant 0.
  - DEFAULT = register-file value.
  - TOP = EX/MEM result, from the instruction one ahead.
  - BOTTOM = MEM/WB result, from the instruction two ahead.
- Internal state: the EX entry (valid, rd, we, is_load) and the MEM entry (valid, rd, we).
- Reset: all entries invalid; ex_valid=0; ex_cmd1=ex_cmd2=DEFAULT; stall=0.
- Per-source select, computed combinationally from ID inputs against current state, in strict priority:
  1. source not used → DEFAULT.
  2. rs==0 → ZERO.
  3. EX valid, we, rd==rs → TOP.
  4. MEM valid, we, rd==rs → BOTTOM.
  5. otherwise DEFAULT.
- Load-use: stall = id_valid & EX valid & EX is_load & EX we & EX rd≠0 & (rs1 matches EX rd with rs1_used, or rs2 matches EX rd with rs2_used).
- stall depends only on current inputs and state; it is asserted even while hold=1.
- Priority per clock edge: rst > flush > hold > normal advance.
- Normal advance (hold=0, flush=0):
  - MEM ← EX.
  - If id_valid & !stall: EX ← ID fields; ex_cmd* ← computed selects; ex_valid←1.
  - Else: EX ← bubble (valid 0); ex_cmd*←DEFAULT; ex_valid←0.
- Entry write-back: an entry with rd=0 or we=0 never matches any source.
- hold=1 (no flush): EX, MEM, ex_cmd*, ex_valid all keep their values.
- flush=1: EX and MEM invalidated; ex_valid←0; ex_cmd*←DEFAULT; the ID instruction is not captured. flush overrides hold.
- The register file is write-through, so a WB-stage writer needs no forwarding; no third level is tracked.
- Latency:
  - ex_cmd* is valid in the cycle after ID presents the instruction with advance.
  - A load-use pair gives exactly one stall cycle, after which the consumer gets BOTTOM.
- Reset mid-stream: all in-flight tags are discarded; the first instruction after reset sees DEFAULT/ZERO only.

Test Plan:
- Back-to-back dependency: I1 writes x5 (non-load), then I2 reads rs1=x5 → I2 enters EX with ex_cmd1=TOP, ex_cmd2=DEFAULT, no stall.
- Distance-2 dependency: I1 writes x7, an independent I2, then I3 reads rs2=x7 → I3 ex_cmd2=BOTTOM. Variant: I1 and I2 both write x7, I3 reads x7 → TOP (nearest wins).
- Load-use: load x3, then I2 reads rs1=x3 → stall=1 for exactly one cycle, EX gets a bubble (ex_valid=0); next cycle I2 enters EX with ex_cmd1=BOTTOM.
- Zero/unused: a writer to x0 followed by a reader of rs1=x0 → ZERO, no stall. A reader with rs2 matching a writer but rs2_used=0 → DEFAULT.
- Hold and flush:
  - hold=1 for 3 cycles with a TOP pending → ex_cmd1 stays TOP; state unchanged on release.
  - flush with load x4 in EX and a reader of x4 in ID → next cycle ex_valid=0, stall=0, the x4 tag is gone.
  - flush and hold asserted together → flush takes effect.
- Reset: assert rst mid-stream with a load in EX and a stall active → next cycle ex_valid=0, ex_cmd*=DEFAULT, stall=0.
